// File: rtl/adder_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter_pkg
//   Shared definitions for the round-robin adder arbiter:
//     - rsp_state_t : occupancy of the one-entry result register
//     - clog2_f     : constant-foldable ceil(log2(v)) used for the id width
//   No ports (package).
// -----------------------------------------------------------------------------
package adder_rr_arbiter_pkg;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

    // ceil(log2(v)) for v >= 2; used at elaboration time only.
    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (((v - 1) >> i) != 0) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter_rr_pick
//   Round-robin picker: finds the first set bit of 'valid' starting at 'ptr'
//   and wrapping modulo R.
//   Ports:
//     ptr    in  RW  starting position of the search
//     valid  in  R   eligible requesters
//     grant  out R   one-hot grant (zero when nothing is eligible)
//     idx    out RW  index of the granted requester (0 when none)
//     any    out 1   at least one requester is eligible
// -----------------------------------------------------------------------------
module adder_rr_arbiter_rr_pick
    import adder_rr_arbiter_pkg::*;
#(
    parameter int R  = 4,
    parameter int RW = clog2_f(R)
) (
    input  logic [RW-1:0] ptr,
    input  logic [R-1:0]  valid,
    output logic [R-1:0]  grant,
    output logic [RW-1:0] idx,
    output logic          any
);

    // Position k steps after p, wrapped into 0..R-1 (R need not be a power of 2).
    function automatic logic [RW-1:0] wrap_add(input logic [RW-1:0] p, input int unsigned k);
        return RW'((32'(p) + k) % R);
    endfunction

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < R; k++) begin
            if (!any && valid[wrap_add(ptr, k)]) begin
                any                    = 1'b1;
                grant[wrap_add(ptr, k)] = 1'b1;
                idx                    = wrap_add(ptr, k);
            end
        end
    end

endmodule

// File: rtl/n_bit_adder.sv
// -----------------------------------------------------------------------------
// n_bit_adder
//   Combinational N-bit adder with carry in/out.
//   Ports:
//     a, b  in  N   operands
//     cin   in  1   carry in
//     sum   out N   a + b + cin modulo 2^N
//     cout  out 1   carry out of bit N-1
// -----------------------------------------------------------------------------
module n_bit_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/adder_rr_arbiter.sv
// -----------------------------------------------------------------------------
// adder_rr_arbiter
//   Shares a single n_bit_adder between R requesters with round-robin
//   arbitration. The granted operands are added combinationally and captured
//   in a one-entry result register drained through a valid/ready port.
//   Throughput is one operation per cycle (drain and refill in the same cycle).
//
//   Optional feature, macro ADDER_ARB_LOCK_EN:
//     adds req_lock; a requester accepted with req_lock=1 keeps exclusive
//     ownership and its carry-out feeds the next add (multi-word chains).
//
//   Ports:
//     clk        in   1     clock, rising edge
//     rst_n      in   1     asynchronous reset, active low
//     req_valid  in   R     requester i has an operation pending
//     req_ready  out  R     one-hot (or zero) accept, combinational
//     req_a      in   R*N   operand A, requester i in [i*N +: N]
//     req_b      in   R*N   operand B, same packing
//     req_cin    in   R     carry in per requester
//     req_lock   in   R     hold grant for chained add (ADDER_ARB_LOCK_EN only)
//     rsp_valid  out  1     result register holds a result
//     rsp_ready  in   1     consumer accepts the result
//     rsp_id     out  RW    owning requester of the result
//     rsp_sum    out  N     a + b + cin modulo 2^N
//     rsp_cout   out  1     carry out of bit N-1
// -----------------------------------------------------------------------------
module adder_rr_arbiter
    import adder_rr_arbiter_pkg::*;
#(
    parameter  int N  = 32,
    parameter  int R  = 4,
    localparam int RW = clog2_f(R)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [R-1:0]    req_valid,
    output logic [R-1:0]    req_ready,
    input  logic [R*N-1:0]  req_a,
    input  logic [R*N-1:0]  req_b,
    input  logic [R-1:0]    req_cin,
`ifdef ADDER_ARB_LOCK_EN
    input  logic [R-1:0]    req_lock,
`endif
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [RW-1:0]   rsp_id,
    output logic [N-1:0]    rsp_sum,
    output logic            rsp_cout
);

    rsp_state_t    state;
    logic [RW-1:0] ptr;
    logic [RW-1:0] ptr_next;

    logic [R-1:0]  eligible;
    logic [R-1:0]  grant;
    logic [RW-1:0] g_idx;
    logic          g_any;

    logic          accept_ok;
    logic          accept;

    logic [N-1:0]  a_sel;
    logic [N-1:0]  b_sel;
    logic          cin_sel;
    logic [N-1:0]  add_sum;
    logic          add_cout;

`ifdef ADDER_ARB_LOCK_EN
    logic          lock_r;
    logic [RW-1:0] owner_r;
    logic          carry_r;
    logic          lock_sel;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef ADDER_ARB_LOCK_EN
    // While locked only the owner may be picked, even if it is idle.
    assign eligible = lock_r ? (req_valid & (R'(1) << owner_r)) : req_valid;
`else
    assign eligible = req_valid;
`endif

    adder_rr_arbiter_rr_pick #(
        .R  (R),
        .RW (RW)
    ) u_pick (
        .ptr   (ptr),
        .valid (eligible),
        .grant (grant),
        .idx   (g_idx),
        .any   (g_any)
    );

    assign rsp_valid = (state == RSP_FULL);
    assign accept_ok = (state == RSP_EMPTY) || rsp_ready;

    // Gated by rst_n so no grant is offered while reset is held.
    assign req_ready = (rst_n && g_any && accept_ok) ? grant : '0;
    assign accept    = |req_ready;

    assign ptr_next  = (g_idx == RW'(R - 1)) ? '0 : g_idx + RW'(1);

    // ------------------------------------------------------------------
    // Operand mux and shared adder
    // ------------------------------------------------------------------
    assign a_sel = req_a[32'(g_idx) * N +: N];
    assign b_sel = req_b[32'(g_idx) * N +: N];

`ifdef ADDER_ARB_LOCK_EN
    assign lock_sel = req_lock[g_idx];
    assign cin_sel  = lock_r ? carry_r : req_cin[g_idx];
`else
    assign cin_sel  = req_cin[g_idx];
`endif

    n_bit_adder #(
        .N (N)
    ) u_adder (
        .a    (a_sel),
        .b    (b_sel),
        .cin  (cin_sel),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // ------------------------------------------------------------------
    // Result register, round-robin pointer and lock state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RSP_EMPTY;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_id   <= '0;
            ptr      <= '0;
`ifdef ADDER_ARB_LOCK_EN
            lock_r   <= 1'b0;
            owner_r  <= '0;
            carry_r  <= 1'b0;
`endif
        end else begin
            case (state)
                RSP_EMPTY: if (accept) state <= RSP_FULL;
                RSP_FULL:  if (!accept && rsp_ready) state <= RSP_EMPTY;
            endcase

            if (accept) begin
                rsp_sum  <= add_sum;
                rsp_cout <= add_cout;
                rsp_id   <= g_idx;
`ifdef ADDER_ARB_LOCK_EN
                // The pointer is frozen for the whole chain; the final
                // unlocking word moves it past the owner (g_idx == owner_r).
                if (lock_sel) begin
                    lock_r  <= 1'b1;
                    owner_r <= g_idx;
                    carry_r <= add_cout;
                end else begin
                    lock_r  <= 1'b0;
                    ptr     <= ptr_next;
                end
`else
                ptr      <= ptr_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;

    localparam int N = 8;
    localparam int R = 4;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] sum;
        logic       cout;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [R-1:0]   req_valid = '0;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a = '0;
    logic [R*N-1:0] req_b = '0;
    logic [R-1:0]   req_cin = '0;
`ifdef ADDER_ARB_LOCK_EN
    logic [R-1:0]   req_lock = '0;
`endif
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_sum;
    logic           rsp_cout;

    logic [7:0] op_a [R];
    logic [7:0] op_b [R];
    logic       op_c [R];

    exp_t sb[$];
    exp_t mon_e;
    exp_t held;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    adder_rr_arbiter #(
        .N (N),
        .R (R)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADDER_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    // Scoreboard: every completed response handshake pops one expectation.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL rsp_unexpected got id=%0d sum=%h cout=%b, expected no response",
                         rsp_id, rsp_sum, rsp_cout);
            end else begin
                mon_e = sb.pop_front();
                if ({rsp_id, rsp_sum, rsp_cout} !== {mon_e.id, mon_e.sum, mon_e.cout}) begin
                    failures++;
                    $display("FAIL rsp_data got id=%0d sum=%h cout=%b, expected id=%0d sum=%h cout=%b",
                             rsp_id, rsp_sum, rsp_cout, mon_e.id, mon_e.sum, mon_e.cout);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
        op_a[i] = a;
        op_b[i] = b;
        op_c[i] = c;
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_cin[i]      = c;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    function automatic exp_t model_of(input int i);
        logic [8:0] t;
        t = {1'b0, op_a[i]} + {1'b0, op_b[i]} + {8'b0, op_c[i]};
        return exp_t'{2'(i), t[7:0], t[8]};
    endfunction

    task automatic do_reset;
        req_valid = '0;
        rsp_ready = 1'b0;
`ifdef ADDER_ARB_LOCK_EN
        req_lock  = '0;
`endif
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready} !== 16'h0) begin
            failures++;
            $display("FAIL reset_state got valid=%b sum=%h cout=%b id=%0d ready=%b, expected all zero",
                     rsp_valid, rsp_sum, rsp_cout, rsp_id, req_ready);
        end
        tick();
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        rsp_ready = 1'b1;
        set_req(0, 8'hFF, 8'h01, 1'b0);
        req_valid = 4'b0001;
        sb.push_back(exp_t'{2'd0, 8'h00, 1'b1});
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL single_grant got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd0, 8'h00, 1'b1}) begin
            failures++;
            $display("FAIL single_latency got valid=%b id=%0d sum=%h cout=%b expected 1/0/00/1",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got rsp_valid=%b expected 0", rsp_valid);
        end
        tick();
    endtask

    task automatic test_round_robin;
        int exp_id;
        do_reset();
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_id = k % R;
            for (int i = 0; i < R; i++) rand_req(i);
            req_valid = 4'hF;
            sb.push_back(model_of(exp_id));
            @(negedge clk);
            checks++;
            if (req_ready !== (4'(1) << exp_id)) begin
                failures++;
                $display("FAIL rr_grant_%0d got %b expected id %0d", k, req_ready, exp_id);
            end
            if (k > 0) begin
                checks++;
                if (rsp_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rr_bubble_%0d got rsp_valid=%b expected 1", k, rsp_valid);
                end
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_backpressure;
        do_reset();
        rsp_ready = 1'b0;
        rand_req(0);
        rand_req(1);
        req_valid = 4'b0011;
        held = model_of(0);
        sb.push_back(held);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL bp_first_grant got %b expected 0001", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, req_ready, rsp_id, rsp_sum, rsp_cout} !==
                {1'b1, 4'b0000, held.id, held.sum, held.cout}) begin
                failures++;
                $display("FAIL bp_hold_%0d got valid=%b ready=%b id=%0d sum=%h cout=%b expected 1/0000/%0d/%h/%b",
                         k, rsp_valid, req_ready, rsp_id, rsp_sum, rsp_cout, held.id, held.sum, held.cout);
            end
            tick();
        end
        rsp_ready = 1'b1;
        sb.push_back(model_of(1));
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL bp_refill got %b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_ptr_skip;
        do_reset();
        rsp_ready = 1'b1;
        rand_req(1);
        req_valid = 4'b0010;
        sb.push_back(model_of(1));
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL skip_setup got %b expected 0010", req_ready);
        end
        tick();
        rand_req(1);
        rand_req(3);
        req_valid = 4'b1010;
        sb.push_back(model_of(3));
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("FAIL skip_first got %b expected 1000", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        sb.push_back(model_of(1));
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL skip_second got %b expected 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

`ifdef ADDER_ARB_LOCK_EN
    task automatic test_lock;
        do_reset();
        rsp_ready = 1'b1;
        rand_req(1);
        req_valid = 4'b0010;
        sb.push_back(model_of(1));
        tick();
        rand_req(0);
        set_req(2, 8'hF0, 8'h20, 1'b0);
        req_lock  = 4'b0100;
        req_valid = 4'b0101;
        sb.push_back(exp_t'{2'd2, 8'h10, 1'b1});
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL lock_first got %b expected 0100", req_ready);
        end
        tick();
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL lock_owner_idle got %b expected 0000", req_ready);
        end
        tick();
        set_req(2, 8'h01, 8'h00, 1'b0);
        req_lock  = 4'b0000;
        req_valid = 4'b0101;
        sb.push_back(exp_t'{2'd2, 8'h02, 1'b0});
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL lock_second got %b expected 0100", req_ready);
        end
        tick();
        req_valid = 4'b0001;
        sb.push_back(model_of(0));
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL lock_release got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask
`endif

    task automatic test_reset_mid;
        do_reset();
        rsp_ready = 1'b0;
        for (int i = 0; i < R; i++) rand_req(i);
        req_valid = 4'b0001;
        sb.push_back(model_of(0));
        tick();
        req_valid = 4'b0111;
        @(negedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({rsp_valid, req_ready} !== 5'b0) begin
            failures++;
            $display("FAIL reset_mid got rsp_valid=%b req_ready=%b expected 0/0000", rsp_valid, req_ready);
        end
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        sb.push_back(model_of(0));
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset_restart got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_ptr_skip();
`ifdef ADDER_ARB_LOCK_EN
        test_lock();
`endif
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
